// File: rtl/lockstep_barrier_matcher.sv
// Per-pair lockstep barrier matcher: checks that primary/shadow cores reach a barrier with equal signatures.
// Optional partner-wait timeout is built when LOCKSTEP_BARRIER_TIMEOUT_EN is defined.
module lockstep_barrier_matcher #(
  parameter int unsigned NB_CORES       = 16,
  parameter int unsigned SIG_WIDTH      = 32,
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic [NB_CORES-1:0]           arrive_i,
  input  logic [NB_CORES*SIG_WIDTH-1:0] sig_i,
  input  logic [NB_CORES/2-1:0]         clear_i,
  output logic [NB_CORES/2-1:0]         barrier_matched_o,
  output logic [NB_CORES/2-1:0]         mismatch_o,
  output logic [NB_CORES/2-1:0]         timeout_o,
  output logic [NB_CORES/2-1:0]         busy_o
);

  localparam int unsigned NB_PAIRS = NB_CORES / 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_P = 2'd1,
    S_WAIT_S = 2'd2,
    S_ERR    = 2'd3
  } state_e;

  if (NB_PAIRS != 8 || TIMEOUT_CYCLES == 0 ||
      64'(TIMEOUT_CYCLES) > (64'd1 << TIMEOUT_W)) begin : g_bad_cfg
    $error("lockstep_barrier_matcher: unsupported parameter set");
  end

  for (genvar p = 0; p < NB_PAIRS; p++) begin : g_pair
    state_e                 r_state, w_state_nxt;
    logic [SIG_WIDTH-1:0]   r_sig, w_sig_nxt;
    logic                   r_match, w_match_nxt;
    logic                   r_mis, w_mis_set;
    logic                   w_arr_p, w_arr_s, w_to_hit;
    logic [SIG_WIDTH-1:0]   w_sig_p, w_sig_s;

    assign w_arr_p = arrive_i[2*p];
    assign w_arr_s = arrive_i[2*p+1];
    assign w_sig_p = sig_i[(2*p)*SIG_WIDTH +: SIG_WIDTH];
    assign w_sig_s = sig_i[(2*p+1)*SIG_WIDTH +: SIG_WIDTH];

    // Clear has priority over disable, which has priority over any arrival.
    always_comb begin
      w_state_nxt = r_state;
      w_sig_nxt   = r_sig;
      w_match_nxt = 1'b0;
      w_mis_set   = 1'b0;
      if (clear_i[p] || !enable_i) begin
        w_state_nxt = S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_arr_p && w_arr_s) begin
              if (w_sig_p == w_sig_s) begin
                w_match_nxt = 1'b1;
              end else begin
                w_state_nxt = S_ERR;
                w_mis_set   = 1'b1;
              end
            end else if (w_arr_p) begin
              w_sig_nxt   = w_sig_p;
              w_state_nxt = S_WAIT_P;
            end else if (w_arr_s) begin
              w_sig_nxt   = w_sig_s;
              w_state_nxt = S_WAIT_S;
            end
          end
          S_WAIT_P: begin
            if (w_arr_p) begin
              w_state_nxt = S_ERR;
              w_mis_set   = 1'b1;
            end else if (w_arr_s) begin
              if (w_sig_s == r_sig) begin
                w_match_nxt = 1'b1;
                w_state_nxt = S_IDLE;
              end else begin
                w_state_nxt = S_ERR;
                w_mis_set   = 1'b1;
              end
            end else if (w_to_hit) begin
              w_state_nxt = S_ERR;
            end
          end
          S_WAIT_S: begin
            if (w_arr_s) begin
              w_state_nxt = S_ERR;
              w_mis_set   = 1'b1;
            end else if (w_arr_p) begin
              if (w_sig_p == r_sig) begin
                w_match_nxt = 1'b1;
                w_state_nxt = S_IDLE;
              end else begin
                w_state_nxt = S_ERR;
                w_mis_set   = 1'b1;
              end
            end else if (w_to_hit) begin
              w_state_nxt = S_ERR;
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= S_IDLE;
        r_sig   <= '0;
        r_match <= 1'b0;
        r_mis   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_sig   <= w_sig_nxt;
        r_match <= w_match_nxt;
        r_mis   <= clear_i[p] ? 1'b0 : (r_mis | w_mis_set);
      end
    end

    assign barrier_matched_o[p] = r_match;
    assign mismatch_o[p]        = r_mis;
    assign busy_o[p]            = (r_state == S_WAIT_P) || (r_state == S_WAIT_S);

`ifdef LOCKSTEP_BARRIER_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] CntLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] r_cnt, w_cnt_nxt;
    logic                 r_to, w_to_set;
    logic                 w_waiting;

    assign w_waiting = (r_state == S_WAIT_P) || (r_state == S_WAIT_S);
    assign w_to_hit  = w_waiting && (r_cnt >= CntLast);
    // A partner arrival in the expiry cycle takes the compare path, so it must not flag a timeout.
    assign w_to_set  = w_to_hit && enable_i && !clear_i[p] && !w_arr_p && !w_arr_s;

    always_comb begin
      w_cnt_nxt = '0;
      if (w_waiting && ((w_state_nxt == S_WAIT_P) || (w_state_nxt == S_WAIT_S))) begin
        w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt <= '0;
        r_to  <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_to  <= clear_i[p] ? 1'b0 : (r_to | w_to_set);
      end
    end

    assign timeout_o[p] = r_to;
`else
    assign w_to_hit     = 1'b0;
    assign timeout_o[p] = 1'b0;
`endif
  end

endmodule
